// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants and FSM encoding for the LCD snapshot scanner
package lcd_pkg;
  localparam int NUM_SLOTS = 12;
  localparam int ADDR_W = 4;
  localparam logic [7:0] TIMEOUT_MARK = 8'hEE;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_NEXT, S_COMMIT} state_t;
endpackage

// File: rtl/lcd_snapshot_scanner_refresh_tick_gen.sv
// refresh_tick_gen: free-running modulo counter producing a one-cycle refresh tick
module refresh_tick_gen #(
  parameter int REFRESH_CYCLES = 5_000_000
) (
  input  logic iCLK,
  input  logic iRST,
  output logic oTICK
);
  localparam int CW = $clog2(REFRESH_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  assign oTICK = cnt_q == CW'(REFRESH_CYCLES - 1);
  always_comb cnt_d = oTICK ? '0 : cnt_q + 1'b1;
  always_ff @(posedge iCLK) cnt_q <= iRST ? '0 : cnt_d;
endmodule

// File: rtl/lcd_snapshot_scanner.sv
// lcd_snapshot_scanner: reads 12 slots into shadow registers and commits them atomically to the LCD bytes
module lcd_snapshot_scanner
  import lcd_pkg::*;
#(
  parameter int REFRESH_CYCLES = 5_000_000,
  parameter int RD_TIMEOUT = 16
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iSTART,
  input  logic              iFREEZE,
  output logic              oRD_REQ,
  output logic [ADDR_W-1:0] oRD_ADDR,
  input  logic [7:0]        iRD_DATA,
  input  logic              iRD_VALID,
  output logic [7:0]        d0x0, d0x1, d0x2, d0x3, d0x4, d0x5,
  output logic [7:0]        d1x0, d1x1, d1x2, d1x3, d1x4, d1x5,
  output logic              oBUSY,
  output logic              oFRAME_DONE,
  output logic              oERR
);
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [TW-1:0] to_q, to_d;
  logic [7:0] shadow_q [NUM_SLOTS];
  logic [7:0] shadow_d [NUM_SLOTS];
  logic [7:0] disp_q [NUM_SLOTS];
  logic [7:0] disp_d [NUM_SLOTS];
  logic done_q, done_d, err_q, err_d, tick;

  refresh_tick_gen #(.REFRESH_CYCLES(REFRESH_CYCLES)) u_tick (
    .iCLK(iCLK), .iRST(iRST), .oTICK(tick)
  );

  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    to_d = to_q;
    shadow_d = shadow_q;
    disp_d = disp_q;
    err_d = err_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: if ((tick || iSTART) && !iFREEZE) begin
        idx_d = '0;
        state_d = S_REQ;
        err_d = iSTART ? 1'b0 : err_q;
      end
      S_REQ: begin
        to_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: if (iRD_VALID) begin
        shadow_d[idx_q] = iRD_DATA;
        state_d = S_NEXT;
      end else if (to_q == TW'(RD_TIMEOUT - 1)) begin
        shadow_d[idx_q] = TIMEOUT_MARK;
        err_d = 1'b1;
        state_d = S_NEXT;
      end else begin
        to_d = to_q + 1'b1;
      end
      S_NEXT: begin
        idx_d = (idx_q == ADDR_W'(NUM_SLOTS - 1)) ? idx_q : idx_q + 1'b1;
        state_d = (idx_q == ADDR_W'(NUM_SLOTS - 1)) ? S_COMMIT : S_REQ;
      end
      S_COMMIT: begin
        // a frozen display keeps the previous frame; the collected data is dropped
        disp_d = iFREEZE ? disp_q : shadow_q;
        done_d = !iFREEZE;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      to_q <= '0;
      shadow_q <= '{default: '0};
      disp_q <= '{default: '0};
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      to_q <= to_d;
      shadow_q <= shadow_d;
      disp_q <= disp_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end

  assign oRD_REQ = state_q == S_REQ;
  assign oRD_ADDR = idx_q;
  assign oBUSY = state_q != S_IDLE;
  assign oFRAME_DONE = done_q;
  assign oERR = err_q;
  assign d0x0 = disp_q[0];
  assign d0x1 = disp_q[1];
  assign d0x2 = disp_q[2];
  assign d0x3 = disp_q[3];
  assign d0x4 = disp_q[4];
  assign d0x5 = disp_q[5];
  assign d1x0 = disp_q[6];
  assign d1x1 = disp_q[7];
  assign d1x2 = disp_q[8];
  assign d1x3 = disp_q[9];
  assign d1x4 = disp_q[10];
  assign d1x5 = disp_q[11];
endmodule

// File: tb/tb_lcd_snapshot_scanner.sv
// tb_lcd_snapshot_scanner: directed stimulus with a frame scoreboard checked on every oFRAME_DONE
module tb_lcd_snapshot_scanner;
  logic iCLK = 0, iRST = 1, iSTART = 0, iFREEZE = 0;
  logic oRD_REQ, oBUSY, oFRAME_DONE, oERR, iRD_VALID;
  logic [3:0] oRD_ADDR;
  logic [7:0] iRD_DATA;
  logic [7:0] d0x0, d0x1, d0x2, d0x3, d0x4, d0x5, d1x0, d1x1, d1x2, d1x3, d1x4, d1x5;
  logic src_valid = 0, inj_valid = 0;
  logic [7:0] src_data = 0, inj_data = 0, base = 8'h30;
  int skip = -1, cyc = 0, checks = 0, errors = 0, done_cnt = 0;
  typedef struct {logic [95:0] f; logic e;} exp_t;
  exp_t sb[$];
  logic [95:0] disp;

  assign iRD_VALID = src_valid | inj_valid;
  assign iRD_DATA = inj_valid ? inj_data : src_data;
  assign disp = {d1x5, d1x4, d1x3, d1x2, d1x1, d1x0, d0x5, d0x4, d0x3, d0x2, d0x1, d0x0};

  lcd_snapshot_scanner #(.REFRESH_CYCLES(100), .RD_TIMEOUT(16)) dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iFREEZE(iFREEZE),
    .oRD_REQ(oRD_REQ), .oRD_ADDR(oRD_ADDR), .iRD_DATA(iRD_DATA), .iRD_VALID(iRD_VALID),
    .d0x0(d0x0), .d0x1(d0x1), .d0x2(d0x2), .d0x3(d0x3), .d0x4(d0x4), .d0x5(d0x5),
    .d1x0(d1x0), .d1x1(d1x1), .d1x2(d1x2), .d1x3(d1x3), .d1x4(d1x4), .d1x5(d1x5),
    .oBUSY(oBUSY), .oFRAME_DONE(oFRAME_DONE), .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;

  // source: answers each request one cycle later with data = addr + base, except the skipped address
  always @(negedge iCLK) begin
    if (oRD_REQ && int'(oRD_ADDR) != skip) begin
      automatic logic [7:0] a = 8'(oRD_ADDR);
      @(posedge iCLK);
      #1 src_valid = 1; src_data = a + base;
      @(posedge iCLK);
      #1 src_valid = 0;
    end
  end

  always @(negedge iCLK) begin
    if (oFRAME_DONE) begin
      done_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL frame_unexpected got=%h required=no frame", disp);
      end else begin
        automatic exp_t x = sb.pop_front();
        if (disp !== x.f) begin
          errors++;
          $display("FAIL frame_data got=%h required=%h", disp, x.f);
        end
        checks++;
        if (oERR !== x.e) begin
          errors++;
          $display("FAIL frame_err got=%b required=%b", oERR, x.e);
        end
      end
    end
  end

  function automatic logic [95:0] mk(input logic [7:0] b, input int sk);
    logic [95:0] f;
    for (int k = 0; k < 12; k++) f[8*k +: 8] = (k == sk) ? 8'hEE : b + 8'(k);
    return f;
  endfunction

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic push(input logic [7:0] b, input int sk, input logic e);
    exp_t x;
    x.f = mk(b, sk);
    x.e = e;
    sb.push_back(x);
  endtask

  task automatic tick1;
    @(posedge iCLK);
    #1;
  endtask

  task automatic start_pulse;
    iSTART = 1;
    tick1();
    iSTART = 0;
  endtask

  task automatic wait_busy(input logic lvl, input int lim, output int at);
    int n = 0;
    while (oBUSY !== lvl && n < lim) begin
      tick1();
      n++;
    end
    chk(lvl ? "busy_rise" : "busy_fall", 96'(oBUSY), 96'(lvl));
    at = cyc;
  endtask

  task automatic wait_req(input int a);
    int n = 0;
    while (!(oRD_REQ && int'(oRD_ADDR) == a) && n < 100) begin
      tick1();
      n++;
    end
    chk("req_seen", 96'(oRD_REQ), 96'(1));
  endtask

  initial begin
    int n, t1, t2, t3, d0;
    repeat (3) @(posedge iCLK);
    #1 iRST = 0;
    chk("rst_disp", disp, 96'h0);
    chk("rst_busy", 96'(oBUSY), 96'(0));
    chk("rst_done", 96'(oFRAME_DONE), 96'(0));
    chk("rst_err", 96'(oERR), 96'(0));
    chk("rst_req", 96'(oRD_REQ), 96'(0));
    chk("rst_addr", 96'(oRD_ADDR), 96'(0));
    // manual frame with 1-cycle source: done 38 cycles after iSTART
    push(8'h30, -1, 0);
    start_pulse();
    n = 1;
    chk("start_busy", 96'(oBUSY), 96'(1));
    chk("start_req", 96'(oRD_REQ), 96'(1));
    chk("start_addr", 96'(oRD_ADDR), 96'(0));
    while (!oFRAME_DONE && n < 100) begin
      tick1();
      n++;
    end
    chk("done_latency", 96'(n), 96'(38));
    // timer-driven frames 100 cycles apart tracking a changing source
    wait_busy(0, 50, t1);
    base = 8'h50;
    push(8'h50, -1, 0);
    wait_busy(1, 150, t1);
    wait_busy(0, 60, t3);
    base = 8'h70;
    push(8'h70, -1, 0);
    wait_busy(1, 150, t2);
    chk("tick_period", 96'(t2 - t1), 96'(100));
    wait_busy(0, 60, t3);
    // manual frame straddling a tick: that tick must be dropped
    while (cyc < t2 + 80) tick1();
    base = 8'h90;
    push(8'h90, -1, 0);
    start_pulse();
    wait_busy(0, 60, t3);
    base = 8'h10;
    push(8'h10, -1, 0);
    wait_busy(1, 150, t1);
    chk("tick_dropped", 96'(t1 - t2), 96'(200));
    wait_busy(0, 60, t3);
    // slot 5 never answers: timeout mark and sticky error
    base = 8'h30;
    skip = 5;
    push(8'h30, 5, 1);
    start_pulse();
    wait_busy(0, 80, t3);
    chk("err_set", 96'(oERR), 96'(1));
    skip = -1;
    base = 8'h20;
    push(8'h20, -1, 1);
    wait_busy(1, 150, t1);
    wait_busy(0, 60, t3);
    base = 8'h40;
    push(8'h40, -1, 0);
    start_pulse();
    chk("err_clear", 96'(oERR), 96'(0));
    wait_busy(0, 60, t3);
    // freeze raised in WAIT of slot 7: no commit, no pulse
    base = 8'hA0;
    wait_busy(1, 150, t1);
    wait_req(7);
    tick1();
    iFREEZE = 1;
    d0 = done_cnt;
    wait_busy(0, 60, t3);
    repeat (2) tick1();
    chk("freeze_disp", disp, mk(8'h40, -1));
    chk("freeze_nodone", 96'(done_cnt), 96'(d0));
    iFREEZE = 0;
    push(8'hA0, -1, 0);
    start_pulse();
    wait_busy(0, 60, t3);
    // valid in the REQ cycle and three cycles later must be ignored
    base = 8'hC0;
    push(8'hC0, -1, 0);
    wait_busy(1, 150, t1);
    wait_req(2);
    inj_valid = 1;
    inj_data = 8'hAA;
    tick1();
    inj_valid = 0;
    repeat (2) tick1();
    inj_valid = 1;
    inj_data = 8'hBB;
    tick1();
    inj_valid = 0;
    wait_busy(0, 60, t3);
    // reset during slot 9 aborts without a partial commit
    base = 8'hE0;
    start_pulse();
    wait_req(9);
    iRST = 1;
    tick1();
    iRST = 0;
    chk("midrst_disp", disp, 96'h0);
    chk("midrst_busy", 96'(oBUSY), 96'(0));
    chk("midrst_done", 96'(oFRAME_DONE), 96'(0));
    chk("midrst_addr", 96'(oRD_ADDR), 96'(0));
    d0 = done_cnt;
    repeat (45) tick1();
    chk("midrst_hold", disp, 96'h0);
    chk("midrst_nodone", 96'(done_cnt), 96'(d0));
    chk("sb_empty", 96'(sb.size()), 96'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1);
  end
endmodule
